// File: rtl/simd_pe_array_if.sv
// Instruction and result bundle for simd_pe_array.
// master drives instructions and observes results; slave is the array.
interface simd_pe_array_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LANES        = 4,
    parameter int unsigned OPCODE_WIDTH = 4
);
    logic                          in_valid;
    logic [OPCODE_WIDTH-1:0]       opcode;
    logic [LANES*DATA_WIDTH-1:0]   a;
    logic [LANES*DATA_WIDTH-1:0]   b;
    logic                          vec_valid;
    logic [LANES*DATA_WIDTH-1:0]   vec_result;
    logic                          red_valid;
    logic [DATA_WIDTH-1:0]         red_result;
    logic [DATA_WIDTH-1:0]         acc_value;
    logic                          busy;

    modport master (
        output in_valid, opcode, a, b,
        input  vec_valid, vec_result, red_valid, red_result, acc_value, busy
    );

    modport slave (
        input  in_valid, opcode, a, b,
        output vec_valid, vec_result, red_valid, red_result, acc_value, busy
    );
endinterface

// File: rtl/simd_pe_array.sv
// SIMD lane ALUs with a registered pairwise adder tree and accumulator stage.
// Element-wise results appear one cycle after issue, reductions after log2(LANES)+2.
module simd_pe_array #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LANES        = 4,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter bit          SATURATE     = 1'b0
) (
    input logic             clk,
    input logic             rst,
    simd_pe_array_if.slave  bus
);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned L     = $clog2(LANES);
    localparam int unsigned NODES = 2 * LANES - 1;
    localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DOTP, OP_MAC, OP_CLR
    } op_e;

    // Tree nodes are stored level by level: level l starts at this offset.
    function automatic int unsigned lvl_off(input int unsigned l);
        return 2 * LANES - 2 * (LANES >> l);
    endfunction

    function automatic logic [DW-1:0] clamp_sum(input logic [DW-1:0] x,
                                                 input logic [DW-1:0] y,
                                                 input logic          sub);
        logic [DW:0] w;
        w = sub ? ({x[DW-1], x} - {y[DW-1], y}) : ({x[DW-1], x} + {y[DW-1], y});
        if (SATURATE && (w[DW] != w[DW-1]))
            return w[DW] ? S_MIN : S_MAX;
        return w[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] clamp_mul(input logic [DW-1:0] x,
                                                 input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = {{DW{x[DW-1]}}, x} * {{DW{y[DW-1]}}, y};
        if (SATURATE && !((&p[2*DW-1:DW-1]) || !(|p[2*DW-1:DW-1])))
            return p[2*DW-1] ? S_MIN : S_MAX;
        return p[DW-1:0];
    endfunction

    op_e             dec_op;
    logic            is_elem;
    logic [DW-1:0]   alu [LANES];

    logic [L:0]      stg_v;
    op_e             stg_op [L+1];
    logic [DW-1:0]   node [NODES];
    logic            vec_v_q;
    logic [LANES*DW-1:0] vec_q;

    logic            acc_v;
    logic            red_v_q;
    logic [DW-1:0]   red_q;
    logic [DW-1:0]   acc;
    logic [DW-1:0]   mac_sum;

    always_comb begin
        dec_op = OP_NOP;
        case (bus.opcode)
            OPCODE_WIDTH'(1): dec_op = OP_ADD;
            OPCODE_WIDTH'(2): dec_op = OP_SUB;
            OPCODE_WIDTH'(3): dec_op = OP_MUL;
            OPCODE_WIDTH'(4): dec_op = OP_DOTP;
            OPCODE_WIDTH'(5): dec_op = OP_MAC;
            OPCODE_WIDTH'(6): dec_op = OP_CLR;
            default:          dec_op = OP_NOP;
        endcase
    end

    assign is_elem = (dec_op == OP_ADD) || (dec_op == OP_SUB) || (dec_op == OP_MUL);

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            alu[i] = '0;
            case (dec_op)
                OP_ADD:  alu[i] = clamp_sum(bus.a[i*DW +: DW], bus.b[i*DW +: DW], 1'b0);
                OP_SUB:  alu[i] = clamp_sum(bus.a[i*DW +: DW], bus.b[i*DW +: DW], 1'b1);
                OP_MUL, OP_DOTP, OP_MAC:
                         alu[i] = clamp_mul(bus.a[i*DW +: DW], bus.b[i*DW +: DW]);
                default: alu[i] = '0;
            endcase
        end
    end

    // Lane stage plus L tree levels; op tags ride alongside so busy stays exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_v   <= '0;
            vec_v_q <= 1'b0;
            vec_q   <= '0;
            for (int unsigned s = 0; s <= L; s++)
                stg_op[s] <= OP_NOP;
            for (int unsigned n = 0; n < NODES; n++)
                node[n] <= '0;
        end else begin
            stg_v     <= {stg_v[L-1:0], bus.in_valid};
            stg_op[0] <= bus.in_valid ? dec_op : OP_NOP;
            for (int unsigned s = 1; s <= L; s++)
                stg_op[s] <= stg_op[s-1];
            vec_v_q <= bus.in_valid && is_elem;
            if (bus.in_valid && is_elem) begin
                for (int unsigned i = 0; i < LANES; i++)
                    vec_q[i*DW +: DW] <= alu[i];
            end
            for (int unsigned i = 0; i < LANES; i++)
                node[i] <= alu[i];
            for (int unsigned l = 1; l <= L; l++) begin
                for (int unsigned k = 0; k < (LANES >> l); k++)
                    node[lvl_off(l) + k] <= node[lvl_off(l-1) + 2*k] + node[lvl_off(l-1) + 2*k + 1];
            end
        end
    end

    assign mac_sum = acc + node[NODES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_v   <= 1'b0;
            red_v_q <= 1'b0;
            red_q   <= '0;
            acc     <= '0;
        end else begin
            acc_v   <= stg_v[L];
            red_v_q <= 1'b0;
            if (stg_v[L]) begin
                case (stg_op[L])
                    OP_DOTP: begin
                        red_q   <= node[NODES-1];
                        red_v_q <= 1'b1;
                    end
                    OP_MAC: begin
                        acc     <= mac_sum;
                        red_q   <= mac_sum;
                        red_v_q <= 1'b1;
                    end
                    OP_CLR:  acc <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.vec_valid  = vec_v_q;
    assign bus.vec_result = vec_q;
    assign bus.red_valid  = red_v_q;
    assign bus.red_result = red_q;
    assign bus.acc_value  = acc;
    assign bus.busy       = (|stg_v) | acc_v;
endmodule
